mag_timer: RTL and testbench

Countdown timer at the far end of the magnetron-control interface. Accepts BCD digits from the keypad as an M:SS cook time and counts down at 1 Hz while the magnetron-enable output of the control block is high. Drives the `timer_done` input of that control block and the three-digit display. Owns the cook-time register and the seconds prescaler; it does not decide when the magnetron runs.

---
 rtl/mag_timer.sv | 177 +++++++++++++++++
 tb/tb_mag_timer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mag_timer.sv
// ---------------------------------------------------------------------------
// mag_timer
//
// Countdown timer sitting at the far end of the magnetron-control interface.
// Keypad digits are shifted in as an M:SS cook time, and the time counts down
// at one step per second while the control block holds the magnetron enable
// high. The timer owns the cook-time register and the seconds prescaler. It
// reports completion back to the control block. It never decides by itself
// when the magnetron runs.
//
// Parameters
//   TICK_DIV     clk cycles per second of countdown (minimum 2)
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   mag_on       magnetron enable, countdown runs only while high
//   clearn       active-low clear button, sampled synchronously
//   digit_valid  one-cycle strobe marking a new keypad entry on digit
//   digit        BCD keypad value (10-15 are ignored)
//   sec_ones     BCD seconds units of the stored time
//   sec_tens     BCD seconds tens of the stored time
//   min_ones     BCD minutes of the stored time
//   timer_done   high while the stored time is 0:00
//   done_pulse   one-cycle pulse after a countdown step lands on 0:00
// ---------------------------------------------------------------------------
module mag_timer #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mag_on,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    // The prescaler must be able to hold TICK_DIV-1. A one-bit counter is
    // still needed when TICK_DIV is 2, because $clog2(2) is 1.
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Each clock edge does exactly one of these actions. They are listed in
    // priority order. Reset is not listed because it is handled in the
    // register block.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLEAR,
        ACT_COUNT,
        ACT_DECR,
        ACT_ENTER
    } action_e;

    action_e action;

    logic [3:0]    secOnes_q, secOnes_d;
    logic [3:0]    secTens_q, secTens_d;
    logic [3:0]    minOnes_q, minOnes_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic          done_q,    done_d;
    logic          pulse_q,   pulse_d;

    logic timeZero;
    logic running;
    logic digitLegal;

    // The stored time counts as zero only when all three digits are zero.
    // The countdown runs only while the magnetron is on and some time is
    // left. At 0:00 everything freezes, which avoids wrapping to 9:59.
    assign timeZero   = (secOnes_q == 4'd0) && (secTens_q == 4'd0) && (minOnes_q == 4'd0);
    assign running    = mag_on && !timeZero;
    assign digitLegal = (digit <= 4'd9);

    // Pick this edge's action. Clear beats the countdown, and the countdown
    // beats keypad entry. Keypad entry is locked out whenever the magnetron
    // is on, even when the time is already 0:00 and nothing is counting.
    always_comb begin
        action = ACT_HOLD;
        if (!clearn) begin
            action = ACT_CLEAR;
        end else if (running) begin
            if (presc_q == TICK_LAST) begin
                action = ACT_DECR;
            end else begin
                action = ACT_COUNT;
            end
        end else if (digit_valid && !mag_on && digitLegal) begin
            action = ACT_ENTER;
        end
    end

    // Next-state datapath. The prescaler defaults to zero. As a result, any
    // edge that is not counting (paused, idle, cleared or at 0:00) discards a
    // partial second, and the next start gets a full second.
    //
    // The decrement borrows like a BCD down-counter. The one special case is
    // a borrow from minutes, which reloads the tens digit to 5. Tens values
    // of 6-9 typed at the keypad are never normalised. They simply count
    // down until the next borrow.
    always_comb begin
        secOnes_d = secOnes_q;
        secTens_d = secTens_q;
        minOnes_d = minOnes_q;
        presc_d   = '0;
        pulse_d   = 1'b0;

        unique case (action)
            ACT_CLEAR: begin
                secOnes_d = 4'd0;
                secTens_d = 4'd0;
                minOnes_d = 4'd0;
            end
            ACT_COUNT: begin
                presc_d = presc_q + 1'b1;
            end
            ACT_DECR: begin
                if (secOnes_q != 4'd0) begin
                    secOnes_d = secOnes_q - 4'd1;
                end else begin
                    secOnes_d = 4'd9;
                    if (secTens_q != 4'd0) begin
                        secTens_d = secTens_q - 4'd1;
                    end else begin
                        secTens_d = 4'd5;
                        minOnes_d = minOnes_q - 4'd1;
                    end
                end
                // Only a step from 0:01 can land on zero. The step is
                // flagged here, so clear and reset can never fire the pulse.
                pulse_d = (secOnes_q == 4'd1) && (secTens_q == 4'd0) && (minOnes_q == 4'd0);
            end
            ACT_ENTER: begin
                minOnes_d = secTens_q;
                secTens_d = secOnes_q;
                secOnes_d = digit;
            end
            default: begin
            end
        endcase

        // The done flag is registered from the next-state time. It therefore
        // changes on the same edge as the digits and never lags by a cycle.
        done_d = (secOnes_d == 4'd0) && (secTens_d == 4'd0) && (minOnes_d == 4'd0);
    end

    // State register. Reset wins over everything and leaves the timer at
    // 0:00 with done asserted. This matches what a clear produces.
    always_ff @(posedge clk) begin
        if (rst) begin
            secOnes_q <= 4'd0;
            secTens_q <= 4'd0;
            minOnes_q <= 4'd0;
            presc_q   <= '0;
            done_q    <= 1'b1;
            pulse_q   <= 1'b0;
        end else begin
            secOnes_q <= secOnes_d;
            secTens_q <= secTens_d;
            minOnes_q <= minOnes_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            pulse_q   <= pulse_d;
        end
    end

    assign sec_ones   = secOnes_q;
    assign sec_tens   = secTens_q;
    assign min_ones   = minOnes_q;
    assign timer_done = done_q;
    assign done_pulse = pulse_q;

endmodule

// File: tb/tb_mag_timer.sv
// ---------------------------------------------------------------------------
// tb_mag_timer
//
// Bench for mag_timer with a short seconds prescaler. Every cycle's stimulus
// goes through an independent behavioural model. The model's expected outputs
// are queued and compared after the edge. Labelled spot checks pin down the
// scenarios that matter most to the control block.
// ---------------------------------------------------------------------------
module tb_mag_timer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       mag_on;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic       timer_done;
    logic       done_pulse;

    mag_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .mag_on      (mag_on),
        .clearn      (clearn),
        .digit_valid (digit_valid),
        .digit       (digit),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .timer_done  (timer_done),
        .done_pulse  (done_pulse)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [13:0] value;
    } expect_t;

    expect_t expQ[$];

    int checkCount = 0;
    int errorCount = 0;
    int pulseCount = 0;

    // The model holds the time as minutes plus a two-digit seconds number.
    // A decrement is done as plain arithmetic on that number. The prescaler
    // is modelled as a count of the cycles spent running.
    int mMin   = 0;
    int mSecs  = 0;
    int mPresc = 0;
    bit mDone  = 1'b1;
    bit mPulse = 1'b0;

    function automatic logic [13:0] packModel();
        return {4'(mMin), 4'(mSecs / 10), 4'(mSecs % 10), mDone, mPulse};
    endfunction

    function automatic logic [13:0] observed();
        return {min_ones, sec_tens, sec_ones, timer_done, done_pulse};
    endfunction

    // Compare one packed output word and report any mismatch field by field.
    task automatic checkOutput(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h:%0h%0h done=%b pulse=%b, want %0h:%0h%0h done=%b pulse=%b",
                     tag, obs[13:10], obs[9:6], obs[5:2], obs[1], obs[0],
                     exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Advance the model by one clock edge, given this edge's inputs.
    task automatic modelStep(input bit r, input bit m, input bit c, input bit v, input int d);
        bit wasNonZero;
        wasNonZero = (mMin != 0) || (mSecs != 0);
        mPulse = 1'b0;
        if (r || !c) begin
            mMin   = 0;
            mSecs  = 0;
            mPresc = 0;
        end else if (m && wasNonZero) begin
            if (mPresc == TICK_DIV - 1) begin
                mPresc = 0;
                if (mSecs > 0) begin
                    mSecs = mSecs - 1;
                end else begin
                    mMin  = mMin - 1;
                    mSecs = 59;
                end
                mPulse = (mMin == 0) && (mSecs == 0);
            end else begin
                mPresc = mPresc + 1;
            end
        end else begin
            mPresc = 0;
            if (!m && v && d <= 9) begin
                mMin  = mSecs / 10;
                mSecs = (mSecs % 10) * 10 + d;
            end
        end
        mDone = (mMin == 0) && (mSecs == 0);
    endtask

    // Drive one cycle of inputs and queue the model's prediction. After the
    // edge, pop the prediction and compare it with what the DUT produced.
    task automatic applyStimulus(input string tag, input bit r, input bit m, input bit c,
                                 input bit v, input logic [3:0] d);
        expect_t e;
        rst         = r;
        mag_on      = m;
        clearn      = c;
        digit_valid = v;
        digit       = d;
        modelStep(r, m, c, v, int'(d));
        e.tag   = tag;
        e.value = packModel();
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput(e.tag, observed(), e.value);
        if (done_pulse) pulseCount++;
    endtask

    task automatic idle(input string tag, input bit m, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, m, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic enterDigit(input logic [3:0] d);
        applyStimulus("entry", 1'b0, 1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic clearTime();
        applyStimulus("clear", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Safety net: stop the run if the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; mag_on = 1'b0; clearn = 1'b1; digit_valid = 1'b0; digit = 4'd0;

        // Reset state and basic keypad entry.
        applyStimulus("reset", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus("reset", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("rstVal", observed(), {4'd0, 4'd0, 4'd0, 1'b1, 1'b0});
        idle("idle", 1'b0, 2);
        enterDigit(4'd1);
        idle("idle", 1'b0, 1);
        enterDigit(4'd3);
        enterDigit(4'd0);
        checkOutput("entry130", observed(), {4'd1, 4'd3, 4'd0, 1'b0, 1'b0});
        enterDigit(4'd12);
        checkOutput("ignore12", observed(), {4'd1, 4'd3, 4'd0, 1'b0, 1'b0});

        // Run 1:00 to zero. Keypad strobes during the run, including some on
        // decrement edges, must be ignored. The pulse must fire exactly once.
        clearTime();
        enterDigit(4'd1); enterDigit(4'd0); enterDigit(4'd0);
        pulseCount = 0;
        idle("run100", 1'b1, 4);
        checkOutput("first59", observed(), {4'd0, 4'd5, 4'd9, 1'b0, 1'b0});
        for (int i = 0; i < 236; i++)
            applyStimulus("run100", 1'b0, 1'b1, 1'b1, (i % 3) == 0, 4'd7);
        idle("holdZero", 1'b1, 20);
        checkOutput("atZero", observed(), {4'd0, 4'd0, 4'd0, 1'b1, 1'b0});
        checkOutput("onePulse100", 14'(pulseCount), 14'd1);

        // Pause and resume: the partial second is lost.
        idle("idle", 1'b0, 1);
        enterDigit(4'd5);
        idle("run005", 1'b1, 6);
        idle("paused", 1'b0, 10);
        checkOutput("frozen", observed(), {4'd0, 4'd0, 4'd4, 1'b0, 1'b0});
        idle("resume", 1'b1, 3);
        checkOutput("noStepYet", observed(), {4'd0, 4'd0, 4'd4, 1'b0, 1'b0});
        idle("resume", 1'b1, 1);
        checkOutput("stepAt4", observed(), {4'd0, 4'd0, 4'd3, 1'b0, 1'b0});

        // Clear in the middle of a second, with the magnetron still on.
        clearTime();
        enterDigit(4'd2);
        pulseCount = 0;
        idle("run002", 1'b1, 2);
        applyStimulus("clrMid", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("clrZero", observed(), {4'd0, 4'd0, 4'd0, 1'b1, 1'b0});
        idle("afterClr", 1'b1, 6);
        checkOutput("clrNoPulse", 14'(pulseCount), 14'd0);

        // Enter 0:73 (tens digit above 5) and count all the way down.
        idle("idle", 1'b0, 1);
        enterDigit(4'd7); enterDigit(4'd3);
        pulseCount = 0;
        idle("run073", 1'b1, 12);
        checkOutput("seq70", observed(), {4'd0, 4'd7, 4'd0, 1'b0, 1'b0});
        idle("run073", 1'b1, 4);
        checkOutput("seq69", observed(), {4'd0, 4'd6, 4'd9, 1'b0, 1'b0});
        idle("run073", 1'b1, 4 * 73 - 16);
        checkOutput("end073", observed(), {4'd0, 4'd0, 4'd0, 1'b1, 1'b1});
        idle("run073", 1'b1, 3);
        checkOutput("onePulse073", 14'(pulseCount), 14'd1);

        // 1:05 to 1:00, then a borrow from the minutes digit.
        idle("idle", 1'b0, 1);
        enterDigit(4'd1); enterDigit(4'd0); enterDigit(4'd5);
        idle("run105", 1'b1, 20);
        checkOutput("at100", observed(), {4'd1, 4'd0, 4'd0, 1'b0, 1'b0});
        idle("run105", 1'b1, 4);
        checkOutput("at059", observed(), {4'd0, 4'd5, 4'd9, 1'b0, 1'b0});

        // Reset in the middle of a run.
        clearTime();
        enterDigit(4'd2); enterDigit(4'd3); enterDigit(4'd4);
        idle("run234", 1'b1, 6);
        applyStimulus("rstMid", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("rstMidVal", observed(), {4'd0, 4'd0, 4'd0, 1'b1, 1'b0});
        idle("afterRst", 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
